fifo_buffer: RTL and testbench
==============================

# fifo_buffer

Single-clock, first-word-fall-through byte FIFO between the MAC receive path and the MAC transmit path of the Ethernet bridge. Received bytes are written when the MAC flags them valid. The head byte is presented continuously to the transmit side, which pops it with `read`. The `full` flag feeds the flow-control logic that issues PAUSE frames, so `full` must be exact and registered.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of each stored word.
- `DEPTH`, 16: number of entries. Must be a power of two, at least 2.
- `ADDR_WIDTH`, log2(DEPTH): pointer width; derived, not overridden.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `write`, input, 1: push `data_in` this cycle.
- `data_in`, input, DATA_WIDTH: word to push.
- `read`, input, 1: pop the current head word this cycle.
- `data_out`, output, DATA_WIDTH: head word; valid whenever `empty`=0; 0 when `empty`=1.
- `empty`, output, 1: FIFO holds 0 words.
- `full`, output, 1: FIFO holds DEPTH words.
- `count`, output, ADDR_WIDTH+1: current number of stored words, 0..DEPTH.
- `overflow`, output, 1: one-cycle pulse; a write was dropped because the FIFO was full.
- `underflow`, output, 1: one-cycle pulse; a read was ignored because the FIFO was empty.

## Operation
- Storage: DEPTH x DATA_WIDTH array.
  - Write pointer `wp` and read pointer `rp`, each ADDR_WIDTH bits, wrap modulo DEPTH.
  - `count` register is ADDR_WIDTH+1 bits.
  - `empty` = (count==0); `full` = (count==DEPTH). Both derived from the registered count, with no combinational path from the inputs.
- Accepted operations, evaluated on each edge:
  - `wr_ok` = write & (!full | read).
  - `rd_ok` = read & !empty.
- `wr_ok`: mem[wp] <= data_in; wp <= wp+1.
- `rd_ok`: rp <= rp+1.
- Count update:
  - count <= count + wr_ok − rd_ok.
  - Both set, or neither set: count unchanged.
- Simultaneous read and write:
  - Empty: only the write is accepted. count 0→1; `underflow` pulses.
  - Full: both are accepted. count stays DEPTH, no `overflow`; the popped word is the old head.
  - Otherwise: both are accepted, count unchanged.
- Write while full without read: word discarded, pointers and memory unchanged, `overflow`=1 for one cycle.
- Read while empty, with or without write: `underflow`=1 for one cycle.
- `data_out` = empty ? 0 : mem[rp]. Combinational read of the head (FWFT).
- Reset (`rst`=0, asynchronous):
  - wp=rp=0, count=0, empty=1, full=0, overflow=0, underflow=0, data_out=0.
  - Memory contents need not be cleared.
  - Reset during traffic discards all stored words immediately.
  - First edge after release behaves as the empty-FIFO case.

## Timing
- Write latency: a word written at edge N appears on `data_out` after edge N, with `empty` falling at the same time, when the FIFO was empty. Readable in cycle N+1.
- Read: `read`=1 at edge N with `empty`=0 consumes the word shown during cycle N-1→N. The next word, or 0 with `empty`=1, is visible after edge N.
- The consumer may hold `read`=!empty continuously; this drains one word per cycle.
- `full` asserts after the edge that stores the DEPTH-th word. It deasserts after the first edge with `rd_ok` and no `wr_ok`.
- `overflow` and `underflow` are registered: high for exactly the cycle after the offending edge.
- No throughput bubbles: one push and one pop per cycle sustained at any fill level.

## Test plan
- Reset, then write 0x11,0x22,0x33 on consecutive cycles with `read`=0 -> after the third edge, count=3, empty=0, data_out=0x11.
- Then hold `read`=1 for 4 cycles -> data_out shows 0x22, 0x33, then 0 with empty=1; `underflow` pulses once on the 4th read.
- Write 16 words 0x00..0x0F with `read`=0, then one more write of 0xAA -> full=1 after the 16th edge; 0xAA dropped, overflow pulses 1 cycle, count stays 16; draining yields 0x00..0x0F in order.
- Full FIFO, `read`=1 and `write`=1 with 0x55 for one cycle -> count stays 16, full stays 1, no overflow; 0x55 emerges after the 16 prior words, which exercises pointer wrap.
- Empty FIFO, `read`=1 and `write`=1 with 0x7E -> count=1, data_out=0x7E next cycle, underflow pulse.
- Fill 5 words, assert `rst`=0 asynchronously mid-cycle -> empty=1, count=0, data_out=0 immediately, without waiting for a clock edge; after release, a write of 0x99 appears alone on `data_out`.

Source files
------------

// File: rtl/fifo_buffer.sv
// rtl/fifo_buffer.sv - single-clock first-word-fall-through FIFO with exact registered full flag
module fifo_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  read,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  empty,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wp;
   logic [ADDR_WIDTH-1:0] rp;
   logic [ADDR_WIDTH:0]   count_next;
   logic                  wr_ok;
   logic                  rd_ok;

   // Flags come only from the registered count so flow control sees no input-to-flag path.
   assign empty = (count == '0);
   assign full  = (count == FULL_COUNT);

   // A write into a full FIFO is still accepted when a pop frees the head slot on the same edge.
   assign wr_ok = write & (~full | read);
   assign rd_ok = read & ~empty;

   // Head word is shown combinationally; zero while nothing is stored.
   assign data_out = empty ? '0 : mem[rp];

   // Next occupancy: push and pop on the same edge cancel out.
   always_comb begin
      count_next = count;
      case ({wr_ok, rd_ok})
         2'b10:   count_next = count + CNT_ONE;
         2'b01:   count_next = count - CNT_ONE;
         default: count_next = count;
      endcase
   end

   // Storage array; contents are not reset since the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wp] <= data_in;
      end
   end

   // Pointers, occupancy and the one-cycle error pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) begin
            wp <= wp + PTR_ONE;
         end
         if (rd_ok) begin
            rp <= rp + PTR_ONE;
         end
         count     <= count_next;
         overflow  <= write & full & ~read;
         underflow <= read & empty;
      end
   end

endmodule

// File: tb/tb_fifo_buffer.sv
// tb/tb_fifo_buffer.sv - directed self-checking bench for fifo_buffer
module tb_fifo_buffer;

   logic       clk;
   logic       rst;
   logic       write;
   logic [7:0] data_in;
   logic       read;
   logic [7:0] data_out;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int n_checks = 0;
   int n_errors = 0;

   fifo_buffer #(.DATA_WIDTH(8), .DEPTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .write     (write),
      .data_in   (data_in),
      .read      (read),
      .data_out  (data_out),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b0;
      write   = 1'b0;
      read    = 1'b0;
      data_in = 8'h00;
      tick();
      tick();
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_dout", data_out, 0);
      check("rst_ovf", overflow, 0);
      check("rst_udf", underflow, 0);
      rst = 1'b1;
      tick();

      // Three writes, no reads.
      write = 1'b1; data_in = 8'h11; tick();
      check("w1_dout", data_out, 8'h11);
      check("w1_empty", empty, 0);
      data_in = 8'h22; tick();
      data_in = 8'h33; tick();
      write = 1'b0;
      check("w3_count", count, 3);
      check("w3_empty", empty, 0);
      check("w3_dout", data_out, 8'h11);

      // Four reads: last one hits an empty FIFO.
      read = 1'b1;
      tick(); check("r1_dout", data_out, 8'h22);
      tick(); check("r2_dout", data_out, 8'h33);
      tick(); check("r3_dout", data_out, 0);
      check("r3_empty", empty, 1);
      check("r3_udf", underflow, 0);
      tick(); check("r4_udf", underflow, 1);
      read = 1'b0;
      tick(); check("r5_udf", underflow, 0);

      // Fill to 16 then attempt one more write.
      write = 1'b1;
      for (int i = 0; i < 16; i++) begin
         data_in = 8'(i);
         tick();
         if (i == 14) check("fill15_full", full, 0);
      end
      check("fill16_full", full, 1);
      check("fill16_count", count, 16);
      data_in = 8'hAA; tick();
      check("ovf_pulse", overflow, 1);
      check("ovf_count", count, 16);
      check("ovf_full", full, 1);
      write = 1'b0; tick();
      check("ovf_clear", overflow, 0);
      check("full_head", data_out, 8'h00);

      // Simultaneous push/pop on a full FIFO.
      write = 1'b1; read = 1'b1; data_in = 8'h55; tick();
      write = 1'b0; read = 1'b0;
      check("frw_count", count, 16);
      check("frw_full", full, 1);
      check("frw_ovf", overflow, 0);
      check("frw_head", data_out, 8'h01);

      // Drain: 0x01..0x0F then 0x55 across the pointer wrap.
      read = 1'b1;
      for (int i = 1; i < 16; i++) begin
         check($sformatf("drain_%0d", i), data_out, i);
         tick();
      end
      check("drain_55", data_out, 8'h55);
      tick();
      read = 1'b0;
      check("drain_empty", empty, 1);
      check("drain_udf", underflow, 0);

      // Simultaneous push/pop on an empty FIFO.
      write = 1'b1; read = 1'b1; data_in = 8'h7E; tick();
      write = 1'b0; read = 1'b0;
      check("erw_count", count, 1);
      check("erw_dout", data_out, 8'h7E);
      check("erw_udf", underflow, 1);
      tick();
      check("erw_udf_clear", underflow, 0);
      check("erw_hold", data_out, 8'h7E);
      read = 1'b1; tick(); read = 1'b0;
      check("erw_drained", empty, 1);

      // Asynchronous reset mid-cycle with data stored.
      write = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         data_in = 8'(i);
         tick();
      end
      write = 1'b0;
      check("pre_rst_count", count, 5);
      #3;
      rst = 1'b0;
      #1;
      check("arst_empty", empty, 1);
      check("arst_count", count, 0);
      check("arst_dout", data_out, 0);
      tick();
      rst = 1'b1;
      write = 1'b1; data_in = 8'h99; tick();
      write = 1'b0;
      check("post_rst_count", count, 1);
      check("post_rst_dout", data_out, 8'h99);
      read = 1'b1; tick(); read = 1'b0;
      check("post_rst_empty", empty, 1);
      check("post_rst_dout0", data_out, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
